// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Walks a fixed ten-entry network descriptor table. For each layer it
//   synchronises with the weight/database loader, then fires the matching
//   engine once per run and waits for that engine's completion handshake.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   GO                    start request (accepted only in IDLE or DONE)
//   step                  current loader step
//   STOP_conv/maxp/dense/res
//                         engine completion levels
//   nextstep              one-cycle pulse asking the loader to advance
//   conv_en/maxp_en/dense_en/result_en
//                         engine enables (one-hot or all low)
//   memstartp/memstartzap read/write buffer bases of the current layer
//   matrix, mem, filt     feature-map side, input-channel code, filter code
//   globmaxp_en           global max-pool enable (layer 7 only)
//   in_dense, out_dense   dense layer sizes
//   layer, run_idx        descriptor index and run counter within the layer
//   STOP                  whole network finished
//   wdog_err              loader did not reach the wanted step in time
module layer_sequencer #(
    parameter int SIZE_address_pix        = 13,
    parameter int picture_storage_limit   = 0,
    parameter int picture_storage_limit_2 = 3136,
    parameter int WDOG_BITS               = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        GO,
    input  logic [4:0]                  step,
    input  logic                        STOP_conv,
    input  logic                        STOP_maxp,
    input  logic                        STOP_dense,
    input  logic                        STOP_res,
    output logic                        nextstep,
    output logic                        conv_en,
    output logic                        maxp_en,
    output logic                        dense_en,
    output logic                        result_en,
    output logic [SIZE_address_pix-1:0] memstartp,
    output logic [SIZE_address_pix-1:0] memstartzap,
    output logic [4:0]                  matrix,
    output logic [4:0]                  mem,
    output logic [4:0]                  filt,
    output logic                        globmaxp_en,
    output logic [4:0]                  in_dense,
    output logic [3:0]                  out_dense,
    output logic [3:0]                  layer,
    output logic [8:0]                  run_idx,
    output logic                        STOP,
    output logic                        wdog_err
);
    localparam int AW = SIZE_address_pix;
    localparam logic [AW-1:0] BUF_A = AW'(picture_storage_limit);
    localparam logic [AW-1:0] BUF_B = AW'(picture_storage_limit_2);
    localparam logic [3:0]    LAST_LAYER = 4'd9;

    typedef enum logic [1:0] {E_CONV, E_MAXP, E_DENSE, E_RES} eng_t;
    typedef enum logic [2:0] {IDLE, LOAD, LWAIT, START, RUN, GAP, DONE} state_t;

    typedef struct packed {
        eng_t          typ;
        logic          has_s;   // layer needs the loader at a given step
        logic [4:0]    s;
        logic [AW-1:0] p;
        logic [AW-1:0] zap;
        logic [4:0]    matrix;
        logic [4:0]    mem;
        logic [4:0]    filt;
        logic          gm;
        logic [8:0]    runs;
        logic [4:0]    ind;
        logic [3:0]    outd;
    } desc_t;

    function automatic desc_t mk(input eng_t typ, input logic has_s, input logic [4:0] s,
                                 input logic [AW-1:0] p, input logic [AW-1:0] zap,
                                 input logic [4:0] mx, input logic [4:0] mm, input logic [4:0] ft,
                                 input logic gm, input logic [8:0] runs,
                                 input logic [4:0] ind, input logic [3:0] outd);
        return '{typ, has_s, s, p, zap, mx, mm, ft, gm, runs, ind, outd};
    endfunction

    // Fields marked "don't care" in the network description are driven as 0.
    function automatic desc_t get_desc(input logic [3:0] l);
        desc_t d;
        d = '0;
        case (l)
            4'd0: d = mk(E_CONV,  1'b1, 5'd3,  BUF_A, BUF_B, 5'd28, 5'd3,  5'd0,  1'b0, 9'd4,   5'd0,  4'd0);
            4'd1: d = mk(E_CONV,  1'b1, 5'd5,  BUF_B, BUF_A, 5'd28, 5'd3,  5'd3,  1'b0, 9'd16,  5'd0,  4'd0);
            4'd2: d = mk(E_MAXP,  1'b0, 5'd0,  BUF_A, BUF_B, 5'd28, 5'd0,  5'd0,  1'b0, 9'd4,   5'd0,  4'd0);
            4'd3: d = mk(E_CONV,  1'b1, 5'd7,  BUF_B, BUF_A, 5'd14, 5'd7,  5'd3,  1'b0, 9'd32,  5'd0,  4'd0);
            4'd4: d = mk(E_CONV,  1'b1, 5'd9,  BUF_A, BUF_B, 5'd14, 5'd7,  5'd7,  1'b0, 9'd64,  5'd0,  4'd0);
            4'd5: d = mk(E_MAXP,  1'b0, 5'd0,  BUF_B, BUF_A, 5'd14, 5'd0,  5'd0,  1'b0, 9'd8,   5'd0,  4'd0);
            4'd6: d = mk(E_CONV,  1'b1, 5'd11, BUF_A, BUF_B, 5'd7,  5'd15, 5'd7,  1'b0, 9'd128, 5'd0,  4'd0);
            4'd7: d = mk(E_CONV,  1'b1, 5'd13, BUF_B, BUF_A, 5'd7,  5'd15, 5'd15, 1'b1, 9'd256, 5'd0,  4'd0);
            4'd8: d = mk(E_DENSE, 1'b1, 5'd15, BUF_A, BUF_B, 5'd0,  5'd0,  5'd0,  1'b0, 9'd1,   5'd16, 4'd11);
            default: d = mk(E_RES, 1'b1, 5'd16, BUF_B, '0,   5'd0,  5'd0,  5'd0,  1'b0, 9'd1,   5'd0,  4'd0);
        endcase
        return d;
    endfunction

    state_t               state, state_n;
    desc_t                d_q;      // latched at LOAD entry, stable for the whole layer
    logic [WDOG_BITS-1:0] wdog, wdog_nxt;
    logic                 sel_stop;
    logic                 go_start, layer_adv, run_adv, net_done, wd_tick, wd_trip;

    always_comb begin
        state_n   = state;
        nextstep  = 1'b0;
        go_start  = 1'b0;
        layer_adv = 1'b0;
        run_adv   = 1'b0;
        net_done  = 1'b0;
        wd_tick   = 1'b0;
        wd_trip   = 1'b0;
        wdog_nxt  = wdog + 1'b1;
        case (d_q.typ)
            E_CONV:  sel_stop = STOP_conv;
            E_MAXP:  sel_stop = STOP_maxp;
            E_DENSE: sel_stop = STOP_dense;
            default: sel_stop = STOP_res;
        endcase
        case (state)
            IDLE, DONE: if (GO) begin
                go_start = 1'b1;
                state_n  = LOAD;
            end
            LOAD: begin
                if (!d_q.has_s || step == d_q.s) begin
                    state_n = START;
                end else begin
                    nextstep = 1'b1;
                    state_n  = LWAIT;
                end
            end
            LWAIT: begin
                if (step == d_q.s) begin
                    state_n = START;
                end else if (&wdog_nxt) begin
                    // counter reaches all-ones on this wait cycle: give up
                    wd_tick = 1'b1;
                    wd_trip = 1'b1;
                    state_n = DONE;
                end else begin
                    wd_tick = 1'b1;
                end
            end
            START: state_n = RUN;
            RUN:   if (sel_stop) state_n = GAP;
            GAP: begin
                // the engine must drop its completion level before re-arming
                if (!sel_stop) begin
                    if (({1'b0, run_idx} + 10'd1) < {1'b0, d_q.runs}) begin
                        run_adv = 1'b1;
                        state_n = START;
                    end else if (layer == LAST_LAYER) begin
                        net_done = 1'b1;
                        state_n  = DONE;
                    end else begin
                        layer_adv = 1'b1;
                        state_n   = LOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            d_q      <= '0;
            wdog     <= '0;
            layer    <= '0;
            run_idx  <= '0;
            STOP     <= 1'b0;
            wdog_err <= 1'b0;
        end else begin
            state <= state_n;
            if (go_start) begin
                layer    <= '0;
                run_idx  <= '0;
                d_q      <= get_desc(4'd0);
                wdog     <= '0;
                STOP     <= 1'b0;
                wdog_err <= 1'b0;
            end
            if (layer_adv) begin
                layer   <= layer + 4'd1;
                run_idx <= '0;
                d_q     <= get_desc(layer + 4'd1);
                wdog    <= '0;
            end
            if (run_adv) run_idx <= run_idx + 9'd1;
            if (net_done) begin
                run_idx <= '0;
                STOP    <= 1'b1;
            end
            if (wd_tick) wdog <= wdog_nxt;
            if (wd_trip) wdog_err <= 1'b1;
        end
    end

    // Enables are a decode of the registered state, so they rise one cycle
    // after START and can never overlap the LOAD-only nextstep pulse.
    assign conv_en   = (state == RUN) && (d_q.typ == E_CONV);
    assign maxp_en   = (state == RUN) && (d_q.typ == E_MAXP);
    assign dense_en  = (state == RUN) && (d_q.typ == E_DENSE);
    assign result_en = (state == RUN) && (d_q.typ == E_RES);

    assign memstartp   = d_q.p;
    assign memstartzap = d_q.zap;
    assign matrix      = d_q.matrix;
    assign mem         = d_q.mem;
    assign filt        = d_q.filt;
    assign in_dense    = d_q.ind;
    assign out_dense   = d_q.outd;
    assign globmaxp_en = d_q.gm && (state != IDLE) && (state != DONE);
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: expected engine runs are queued by
// the stimulus, the monitor pops one on every enable rising edge.
module tb_layer_sequencer;
    logic        clk = 1'b0;
    logic        reset, GO;
    logic [4:0]  step, man_step, auto_step;
    logic        auto_ld, spur;
    logic [3:0]  stop_m;
    logic        STOP_conv, STOP_maxp, STOP_dense, STOP_res;
    logic        nextstep, conv_en, maxp_en, dense_en, result_en;
    logic [12:0] memstartp, memstartzap;
    logic [4:0]  matrix, mem, filt, in_dense;
    logic        globmaxp_en, STOP, wdog_err;
    logic [3:0]  out_dense, layer;
    logic [8:0]  run_idx;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    assign step       = auto_ld ? auto_step : man_step;
    assign STOP_conv  = stop_m[0];
    assign STOP_maxp  = stop_m[1] | spur;
    assign STOP_dense = stop_m[2];
    assign STOP_res   = stop_m[3];

    layer_sequencer #(.WDOG_BITS(4)) dut (
        .clk(clk), .reset(reset), .GO(GO), .step(step),
        .STOP_conv(STOP_conv), .STOP_maxp(STOP_maxp), .STOP_dense(STOP_dense), .STOP_res(STOP_res),
        .nextstep(nextstep), .conv_en(conv_en), .maxp_en(maxp_en), .dense_en(dense_en),
        .result_en(result_en), .memstartp(memstartp), .memstartzap(memstartzap),
        .matrix(matrix), .mem(mem), .filt(filt), .globmaxp_en(globmaxp_en),
        .in_dense(in_dense), .out_dense(out_dense), .layer(layer), .run_idx(run_idx),
        .STOP(STOP), .wdog_err(wdog_err)
    );

    wire [3:0]  en_w = {result_en, dense_en, maxp_en, conv_en};
    wire [70:0] all_out = {nextstep, en_w, memstartp, memstartzap, matrix, mem, filt,
                           globmaxp_en, in_dense, out_dense, layer, run_idx, STOP, wdog_err};

    // Network table (hand transcribed), don't-care fields expected as 0.
    localparam int T_EN[10]   = '{1, 1, 2, 1, 1, 2, 1, 1, 4, 8};
    localparam int T_P[10]    = '{0, 3136, 0, 3136, 0, 3136, 0, 3136, 0, 3136};
    localparam int T_ZAP[10]  = '{3136, 0, 3136, 0, 3136, 0, 3136, 0, 3136, 0};
    localparam int T_MX[10]   = '{28, 28, 28, 14, 14, 14, 7, 7, 0, 0};
    localparam int T_MEM[10]  = '{3, 3, 0, 7, 7, 0, 15, 15, 0, 0};
    localparam int T_FILT[10] = '{0, 3, 0, 3, 7, 0, 7, 15, 0, 0};
    localparam int T_RUNS[10] = '{4, 16, 4, 32, 64, 8, 128, 256, 1, 1};

    typedef struct packed {
        logic [3:0]  layer;
        logic [8:0]  run;
        logic [3:0]  en;
        logic [12:0] p;
        logic [12:0] zap;
        logic [4:0]  matrix;
        logic [4:0]  mem;
        logic [4:0]  filt;
        logic        gm;
        logic [4:0]  ind;
        logic [3:0]  outd;
    } ev_t;

    ev_t exp_q[$];

    function automatic int lat_of(input int i);
        case (i)
            0: return 20;
            1: return 6;
            2: return 8;
            default: return 4;
        endcase
    endfunction

    task automatic push_runs(input int l, input int r0, input int n);
        for (int r = r0; r < r0 + n; r++) begin
            ev_t e;
            e.layer  = 4'(l);
            e.run    = 9'(r);
            e.en     = 4'(T_EN[l]);
            e.p      = 13'(T_P[l]);
            e.zap    = 13'(T_ZAP[l]);
            e.matrix = 5'(T_MX[l]);
            e.mem    = 5'(T_MEM[l]);
            e.filt   = 5'(T_FILT[l]);
            e.gm     = (l == 7);
            e.ind    = (l == 8) ? 5'd16 : 5'd0;
            e.outd   = (l == 8) ? 4'd11 : 4'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Engine model: raise completion lat cycles after enable, drop when enable drops.
    int ecnt[4];
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (en_w[i]) begin
                if (!stop_m[i]) begin
                    ecnt[i]++;
                    if (ecnt[i] == lat_of(i)) stop_m[i] = 1'b1;
                end
            end else begin
                stop_m[i] = 1'b0;
                ecnt[i]   = 0;
            end
        end
    end

    // Loader model: in auto mode advance to the next step a few cycles after nextstep.
    int ld_cnt = 0;
    always @(negedge clk) begin
        if (!auto_ld) begin
            auto_step = man_step;
            ld_cnt    = 0;
        end else if (ld_cnt > 0) begin
            ld_cnt--;
            if (ld_cnt == 0) auto_step = (auto_step >= 5'd15) ? 5'd16 : auto_step + 5'd2;
        end else if (nextstep) begin
            ld_cnt = 3;
        end
    end

    // Monitor / scoreboard
    logic [3:0] en_prev = '0;
    int hi_cnt = 0;
    always @(negedge clk) begin
        if (nextstep) chk("nextstep_vs_en", 80'(en_w), 80'(0));
        if (en_w != 4'd0 && en_prev == 4'd0) begin
            ev_t act;
            act.layer  = layer;
            act.run    = run_idx;
            act.en     = en_w;
            act.p      = memstartp;
            act.zap    = memstartzap;
            act.matrix = matrix;
            act.mem    = mem;
            act.filt   = filt;
            act.gm     = globmaxp_en;
            act.ind    = in_dense;
            act.outd   = out_dense;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_run", 80'(act), 80'(0));
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("sb_run", 80'(act), 80'(e));
            end
        end
        if (en_w != 4'd0) hi_cnt++;
        if (en_w == 4'd0 && en_prev != 4'd0) begin
            if (!reset) begin
                int li = 0;
                for (int i = 0; i < 4; i++) if (en_prev[i]) li = i;
                chk("enable_width", 80'(hi_cnt), 80'(lat_of(li)));
            end
            hi_cnt = 0;
        end
        en_prev = en_w;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k, ns_cnt;
        reset = 1'b1; GO = 1'b1; man_step = 5'd3; auto_ld = 1'b0; spur = 1'b0;
        stop_m = '0;

        // reset wins over GO, outputs at reset values
        tick(1);
        chk("reset_vals", 80'(all_out), 80'(0));
        tick(1);
        reset = 1'b0; GO = 1'b0;
        tick(4);
        chk("idle_after_reset", 80'(all_out), 80'(0));

        // Phase 1: step already 3, first layer starts without nextstep
        push_runs(0, 0, 4);
        push_runs(1, 0, 1);
        GO = 1'b1; tick(1); GO = 1'b0;
        chk("go_load", 80'({conv_en, nextstep}), 80'(0));
        tick(1);
        chk("go_start", 80'({conv_en, nextstep}), 80'(0));
        tick(1);
        chk("go_conv_rise", 80'({conv_en, memstartp, memstartzap, matrix}),
            80'({1'b1, 13'd0, 13'd3136, 5'd28}));
        spur = 1'b1; tick(5); spur = 1'b0;   // foreign completion must be ignored
        for (k = 0; k < 500 && !nextstep; k++) tick(1);
        chk("l1_nextstep", 80'({nextstep, layer}), 80'({1'b1, 4'd1}));
        ns_cnt = 0;
        repeat (10) begin tick(1); ns_cnt += int'(nextstep); end
        chk("l1_single_pulse", 80'(ns_cnt), 80'(0));
        man_step = 5'd5;
        for (k = 0; k < 10 && !conv_en; k++) tick(1);
        chk("l1_conv_after_step", 80'({conv_en, filt, memstartp}), 80'({1'b1, 5'd3, 13'd3136}));
        tick(3);
        reset = 1'b1; tick(1);
        chk("reset_midrun_l1", 80'(all_out), 80'(0));
        tick(1); reset = 1'b0;
        chk("p1_queue_empty", 80'(exp_q.size()), 80'(0));

        // Phase 2: loader stuck at step 3 in layer 1 -> watchdog
        man_step = 5'd3;
        push_runs(0, 0, 4);
        GO = 1'b1; tick(1); GO = 1'b0;
        for (k = 0; k < 300 && !nextstep; k++) tick(1);
        chk("wd_nextstep", 80'({nextstep, layer}), 80'({1'b1, 4'd1}));
        ns_cnt = 0;
        repeat (15) begin tick(1); ns_cnt += int'(nextstep); end
        chk("wd_not_yet", 80'(wdog_err), 80'(0));
        tick(1);
        chk("wd_trip", 80'({wdog_err, STOP, en_w}), 80'({1'b1, 1'b0, 4'd0}));
        tick(3);
        chk("wd_hold", 80'({wdog_err, STOP, en_w, ns_cnt[3:0]}), 80'({1'b1, 1'b0, 4'd0, 4'd0}));
        chk("p2_queue_empty", 80'(exp_q.size()), 80'(0));

        // Phase 3: full network from DONE with a responsive loader
        auto_ld = 1'b1;
        for (int l = 0; l < 10; l++) push_runs(l, 0, T_RUNS[l]);
        GO = 1'b1; tick(1); GO = 1'b0;
        for (k = 0; k < 3000 && layer != 4'd3; k++) tick(1);
        chk("reach_layer3", 80'(layer), 80'(3));
        GO = 1'b1; tick(1); GO = 1'b0;     // must be ignored mid-network
        for (k = 0; k < 40000 && !STOP; k++) tick(1);
        chk("net_stop", 80'(STOP), 80'(1));
        tick(5);
        chk("net_stop_hold", 80'({STOP, en_w, layer, wdog_err}), 80'({1'b1, 4'd0, 4'd9, 1'b0}));
        chk("p3_queue_empty", 80'(exp_q.size()), 80'(0));

        // Phase 4: reset during a layer-4 run, then restart at layer 0
        auto_ld = 1'b0; man_step = 5'd3; tick(1); auto_ld = 1'b1;
        for (int l = 0; l < 4; l++) push_runs(l, 0, T_RUNS[l]);
        push_runs(4, 0, 1);
        GO = 1'b1; tick(1); GO = 1'b0;
        for (k = 0; k < 5000 && !(layer == 4'd4 && conv_en); k++) tick(1);
        chk("reach_layer4_run", 80'({layer, conv_en}), 80'({4'd4, 1'b1}));
        tick(5);
        reset = 1'b1; tick(1);
        chk("reset_midrun_l4", 80'(all_out), 80'(0));
        tick(1); reset = 1'b0;
        chk("p4_queue_empty", 80'(exp_q.size()), 80'(0));
        auto_ld = 1'b0; man_step = 5'd3;
        push_runs(0, 0, 1);
        GO = 1'b1; tick(1); GO = 1'b0;
        for (k = 0; k < 20 && !conv_en; k++) tick(1);
        chk("restart_layer0", 80'({conv_en, layer, run_idx}), 80'({1'b1, 4'd0, 9'd0}));
        reset = 1'b1; tick(2); reset = 1'b0;
        chk("final_queue_empty", 80'(exp_q.size()), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
